// File: rtl/harvard_data_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | harvard_data_bridge_if : CPU data-port and wait-request memory bus bundle |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface harvard_data_bridge_if;
    logic        cpu_active;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_clk_enable;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        fault;

    modport master (
        input  cpu_active, cpu_address, cpu_read, cpu_write, cpu_writedata,
        input  mem_waitrequest, mem_readdata,
        output cpu_readdata, cpu_clk_enable,
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        output fault
    );

    modport slave (
        output cpu_active, cpu_address, cpu_read, cpu_write, cpu_writedata,
        output mem_waitrequest, mem_readdata,
        input  cpu_readdata, cpu_clk_enable,
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        input  fault
    );
endinterface
`default_nettype wire

// File: rtl/harvard_data_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | harvard_data_bridge : stalls the CPU data port over a wait-request bus.   |
// | Optional bus-timeout abort: HARVARD_DATA_BRIDGE_TIMEOUT_EN. Rev 1.0       |
// +--------------------------------------------------------------------------+
module harvard_data_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] FAULT_DATA     = 32'h0000_0000
) (
    input  wire logic              clk,
    input  wire logic              reset,
    harvard_data_bridge_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state,          w_state_nxt;
    logic [31:0] r_mem_address,    w_mem_address_nxt;
    logic        r_mem_read,       w_mem_read_nxt;
    logic        r_mem_write,      w_mem_write_nxt;
    logic [31:0] r_mem_writedata,  w_mem_writedata_nxt;
    logic [3:0]  r_mem_byteenable, w_mem_byteenable_nxt;
    logic [31:0] r_read_buf,       w_read_buf_nxt;
    logic        w_clk_en;
    logic        w_req;
    logic        w_unused;

    assign w_req = bus.cpu_active & (bus.cpu_read | bus.cpu_write);

`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
    localparam int c_cnt_w = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_fault, w_fault_nxt;
    logic               w_timeout;

    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT_CYCLES));
    assign w_unused  = ^bus.cpu_address[1:0];
`else
    assign w_unused  = ^{bus.cpu_address[1:0], FAULT_DATA, TIMEOUT_CYCLES};
`endif

    always_comb begin
        w_state_nxt          = r_state;
        w_mem_address_nxt    = r_mem_address;
        w_mem_read_nxt       = r_mem_read;
        w_mem_write_nxt      = r_mem_write;
        w_mem_writedata_nxt  = r_mem_writedata;
        w_mem_byteenable_nxt = r_mem_byteenable;
        w_read_buf_nxt       = r_read_buf;
        w_clk_en             = 1'b0;
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
        w_cnt_nxt            = r_cnt;
        w_fault_nxt          = r_fault;
`endif
        case (r_state)
            IDLE: begin
                w_clk_en = !w_req;
                if (w_req) begin
                    // A simultaneous read+write request is treated as a write.
                    w_mem_address_nxt    = {bus.cpu_address[31:2], 2'b00};
                    w_mem_writedata_nxt  = bus.cpu_writedata;
                    w_mem_read_nxt       = !bus.cpu_write;
                    w_mem_write_nxt      = bus.cpu_write;
                    w_mem_byteenable_nxt = 4'b1111;
                    w_state_nxt          = BUSY;
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
                    w_cnt_nxt            = '0;
`endif
                end
            end
            BUSY: begin
                if (!bus.mem_waitrequest) begin
                    if (r_mem_read) begin
                        w_read_buf_nxt = bus.mem_readdata;
                    end
                    w_mem_read_nxt       = 1'b0;
                    w_mem_write_nxt      = 1'b0;
                    w_mem_byteenable_nxt = 4'b0000;
                    w_state_nxt          = DONE;
                end
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
                else if (w_timeout) begin
                    if (r_mem_read) begin
                        w_read_buf_nxt = FAULT_DATA;
                    end
                    w_mem_read_nxt       = 1'b0;
                    w_mem_write_nxt      = 1'b0;
                    w_mem_byteenable_nxt = 4'b0000;
                    w_fault_nxt          = 1'b1;
                    w_state_nxt          = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                // The CPU commits on this edge; its stale request is ignored.
                w_clk_en    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_mem_address    <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_writedata  <= '0;
            r_mem_byteenable <= '0;
            r_read_buf       <= '0;
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
            r_cnt            <= '0;
            r_fault          <= 1'b0;
`endif
        end else begin
            r_state          <= w_state_nxt;
            r_mem_address    <= w_mem_address_nxt;
            r_mem_read       <= w_mem_read_nxt;
            r_mem_write      <= w_mem_write_nxt;
            r_mem_writedata  <= w_mem_writedata_nxt;
            r_mem_byteenable <= w_mem_byteenable_nxt;
            r_read_buf       <= w_read_buf_nxt;
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
            r_cnt            <= w_cnt_nxt;
            r_fault          <= w_fault_nxt;
`endif
        end
    end

    assign bus.cpu_readdata   = r_read_buf;
    assign bus.cpu_clk_enable = w_clk_en;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_read       = r_mem_read;
    assign bus.mem_write      = r_mem_write;
    assign bus.mem_writedata  = r_mem_writedata;
    assign bus.mem_byteenable = r_mem_byteenable;
`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
    assign bus.fault          = r_fault;
`else
    assign bus.fault          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_harvard_data_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_harvard_data_bridge : randomized CPU/memory traffic vs. word memory    |
// | reference model. Rev 1.0                                                  |
// +--------------------------------------------------------------------------+
module tb_harvard_data_bridge;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [31:0] mem_model [16];
    logic [31:0] last_read;

    harvard_data_bridge_if bus ();

    harvard_data_bridge #(
        .TIMEOUT_CYCLES (4),
        .FAULT_DATA     (32'hDEADBEEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Cycles with no request: CPU runs freely and the bus stays quiet.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cpu_active = $urandom_range(0, 1);
            if (bus.cpu_active) begin
                bus.cpu_read  = 1'b0;
                bus.cpu_write = 1'b0;
            end else begin
                bus.cpu_read  = $urandom_range(0, 1);
                bus.cpu_write = $urandom_range(0, 1);
            end
            bus.cpu_address = $urandom;
            #1;
            check("idle_clk_en", 32'(bus.cpu_clk_enable), 32'd1);
            check("idle_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
            step();
        end
    endtask

    // One CPU access; the bench plays the memory with nwait wait cycles.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] wdata, input int nwait);
        int   idx;
        int   waits_left;
        int   stalls;
        int   strobes;
        logic done;
        idx        = int'(addr[5:2]);
        waits_left = nwait;
        stalls     = 0;
        strobes    = 0;
        done       = 1'b0;
        bus.cpu_active    = 1'b1;
        bus.cpu_read      = rd;
        bus.cpu_write     = wr;
        bus.cpu_address   = addr;
        bus.cpu_writedata = wdata;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (bus.mem_read || bus.mem_write) begin
                strobes++;
                check("strobe_type", {30'd0, bus.mem_write, bus.mem_read}, wr ? 32'd2 : 32'd1);
                check("mem_address", bus.mem_address, {addr[31:2], 2'b00});
                check("byteenable", 32'(bus.mem_byteenable), 32'hF);
                if (wr) check("mem_writedata", bus.mem_writedata, wdata);
                if (waits_left > 0) begin
                    bus.mem_waitrequest = 1'b1;
                    bus.mem_readdata    = $urandom;
                    waits_left--;
                end else begin
                    bus.mem_waitrequest = 1'b0;
                    bus.mem_readdata    = mem_model[idx];
                end
            end else begin
                bus.mem_waitrequest = $urandom_range(0, 1);
                bus.mem_readdata    = $urandom;
            end
            if (bus.cpu_clk_enable) done = 1'b1;
            else stalls++;
            step();
        end
        check("access_done", 32'(done), 32'd1);
        check("stall_cycles", 32'(stalls), 32'(2 + nwait));
        check("strobe_cycles", 32'(strobes), 32'(1 + nwait));
        if (wr) mem_model[idx] = wdata;
        else    last_read      = mem_model[idx];
        bus.cpu_active = 1'b0;
        #1;
        check("cpu_readdata", bus.cpu_readdata, last_read);
    endtask

    initial begin
        int   kind;
        logic [31:0] a;
        clk      = 1'b0;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        mem_model[1]        = 32'hCAFEBABE;
        last_read           = 32'd0;
        reset               = 1'b0;
        bus.cpu_active      = 1'b1;
        bus.cpu_read        = 1'b1;
        bus.cpu_write       = 1'b0;
        bus.cpu_address     = 32'h1000_0006;
        bus.cpu_writedata   = 32'd0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'd0;

        step();
        step();
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_byteenable", 32'(bus.mem_byteenable), 32'd0);
        check("rst_mem_address", bus.mem_address, 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_readdata", bus.cpu_readdata, 32'd0);
        reset = 1'b1;
        #1;
        check("post_rst_clk_en", 32'(bus.cpu_clk_enable), 32'd0);

        do_access(1'b0, 1'b1, 32'h1000_0006, 32'd0, 0);
        check("load_value", bus.cpu_readdata, 32'hCAFEBABE);
        idle_cycles(1);

        do_access(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 3);
        idle_cycles(2);

        do_access(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 1);
        bus.cpu_active = 1'b0;
        bus.cpu_read   = 1'b1;
        bus.cpu_write  = 1'b1;
        #1;
        check("inactive_clk_en", 32'(bus.cpu_clk_enable), 32'd1);
        step();
        check("inactive_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);

        // Reset dropped in the middle of a stalled read.
        bus.cpu_active      = 1'b1;
        bus.cpu_read        = 1'b1;
        bus.cpu_write       = 1'b0;
        bus.cpu_address     = 32'h0000_0008;
        bus.mem_waitrequest = 1'b1;
        step();
        check("busy_mem_read", 32'(bus.mem_read), 32'd1);
        step();
        reset = 1'b0;
        step();
        #1;
        check("midrst_mem_read", 32'(bus.mem_read), 32'd0);
        check("midrst_no_done", 32'(bus.cpu_clk_enable), 32'd0);
        check("midrst_readdata", bus.cpu_readdata, 32'd0);
        last_read      = 32'd0;
        bus.cpu_active = 1'b0;
        reset          = 1'b1;
        idle_cycles(2);

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            a    = 32'h1000_0000 | ($urandom & 32'h3F);
            do_access(kind != 0, kind != 1, a, $urandom, $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

`ifdef HARVARD_DATA_BRIDGE_TIMEOUT_EN
        begin
            int stalls;
            logic done;
            stalls = 0;
            done   = 1'b0;
            bus.cpu_active      = 1'b1;
            bus.cpu_read        = 1'b1;
            bus.cpu_write       = 1'b0;
            bus.cpu_address     = 32'h0000_0004;
            bus.mem_waitrequest = 1'b1;
            for (int cyc = 0; cyc < 64 && !done; cyc++) begin
                #1;
                if (bus.cpu_clk_enable) done = 1'b1;
                else stalls++;
                step();
            end
            bus.cpu_active = 1'b0;
            #1;
            check("to_done", 32'(done), 32'd1);
            check("to_stalls", 32'(stalls), 32'd6);
            check("to_readdata", bus.cpu_readdata, 32'hDEADBEEF);
            check("to_fault", 32'(bus.fault), 32'd1);
            step();
            check("to_fault_sticky", 32'(bus.fault), 32'd1);
            reset = 1'b0;
            step();
            reset = 1'b1;
        end
`endif
        check("final_fault", 32'(bus.fault), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
